// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller with byte/half/word access, sign/zero extension,
// alignment and range fault detection, and a configurable number of access wait states.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);
    // Handshake: a request transfers on a rising edge with req_valid && req_ready;
    // a response transfers on a rising edge with rsp_valid && rsp_ready.
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_uns;
    logic [31:0] sel_wdata;
    logic        accept;
    logic        commit;
    logic        access_err;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;
    logic [3:0]  be;
    logic [31:0] wr_lanes;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);
    assign dbg_state = state;
    assign accept    = req_valid && (state == IDLE);
    // With no wait states the access happens on the accept edge, so it uses the live request.
    assign commit    = ((state == WAIT) && (cnt == 4'd0)) || (accept && (WAIT_STATES == 0));

    always_comb begin
        if (state == IDLE) begin
            sel_we    = req_we;
            sel_addr  = req_addr;
            sel_size  = req_size;
            sel_uns   = req_unsigned;
            sel_wdata = req_wdata;
        end else begin
            sel_we    = r_we;
            sel_addr  = r_addr;
            sel_size  = r_size;
            sel_uns   = r_uns;
            sel_wdata = r_wdata;
        end
    end

    always_comb begin
        access_err = 1'b0;
        case (sel_size)
            2'b00:   access_err = 1'b0;
            2'b01:   access_err = sel_addr[0];
            2'b10:   access_err = (sel_addr[1:0] != 2'b00);
            default: access_err = 1'b1;
        endcase
        if (|sel_addr[31:AW+2]) access_err = 1'b1;
    end

    assign word_idx = sel_addr[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign byte_v   = rd_word[{sel_addr[1:0], 3'b000} +: 8];
    assign half_v   = rd_word[{sel_addr[1], 4'b0000} +: 16];

    always_comb begin
        load_data = 32'd0;
        case (sel_size)
            2'b00:   load_data = sel_uns ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_data = sel_uns ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            2'b10:   load_data = rd_word;
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        be       = 4'b0000;
        wr_lanes = sel_wdata;
        case (sel_size)
            2'b00: begin
                be[sel_addr[1:0]] = 1'b1;
                wr_lanes          = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                be       = sel_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{sel_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = be[i] ? wr_lanes[i*8 +: 8] : rd_word[i*8 +: 8];
        end
    end

    // Array has no reset: contents survive rst_n and start undefined.
    always_ff @(posedge clk) begin
        if (commit && sel_we && !access_err) begin
            mem[word_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_size    <= 2'b00;
            r_uns     <= 1'b0;
            r_wdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_wdata <= req_wdata;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    else             state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= access_err;
                rsp_rdata <= (access_err || sel_we) ? 32'd0 : load_data;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (1, 3 and 0 wait states) checked with vector
// tables, hand sequences for stall/reset/back-to-back, and a random run against a model.
module tb_data_mem_ctrl;
    localparam int DEPTH = 4096;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n        [3];
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_we       [3];
    logic [31:0] req_addr     [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_wdata    [3];
    logic        rsp_valid    [3];
    logic        rsp_ready    [3];
    logic [31:0] rsp_rdata    [3];
    logic        rsp_err      [3];
    logic [1:0]  dbg_state    [3];

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [int];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .dbg_state(dbg_state[0]));
    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .dbg_state(dbg_state[1]));
    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_size(req_size[2]),
        .req_unsigned(req_unsigned[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
        .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
        .dbg_state(dbg_state[2]));

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
               || ((a >> 2) >= 32'(DEPTH));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        v = w >> (8 * int'(a[1:0]));
        if (sz == 2'd0) begin
            v &= 32'hFF;
            if (!uns && v[7]) v |= 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v &= 32'hFFFF;
            if (!uns && v[15]) v |= 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        sh   = 8 * int'(a[1:0]);
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic drive_req(input int k, input logic we, input logic [31:0] addr,
                             input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        req_valid[k]    = 1'b1;
        req_we[k]       = we;
        req_addr[k]     = addr;
        req_size[k]     = size;
        req_unsigned[k] = uns;
        req_wdata[k]    = wdata;
    endtask

    task automatic scramble_req(input int k);
        req_valid[k]    = 1'b0;
        req_we[k]       = 1'($urandom);
        req_addr[k]     = $urandom;
        req_size[k]     = 2'($urandom);
        req_unsigned[k] = 1'($urandom);
        req_wdata[k]    = $urandom;
    endtask

    task automatic wait_rsp(input int k, output logic [31:0] rdata, output logic err,
                            output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[k] && lat < 50);
        if (!rsp_valid[k]) chk("rsp_timeout", 32'(rsp_valid[k]), 32'd1);
        rdata = rsp_rdata[k];
        err   = rsp_err[k];
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic xact(input int k, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        guard = 0;
        while (!req_ready[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        drive_req(k, we, addr, size, uns, wdata);
        @(posedge clk);
        #1 scramble_req(k);
        wait_rsp(k, rdata, err, lat);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t        vecs [$];
        vec_t        b2b  [$];
        vec_t        pv;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          guard;
        int          item;
        logic        pend;

        for (int k = 0; k < 3; k++) begin
            rst_n[k]     = 1'b0;
            rsp_ready[k] = (k == 2);
            scramble_req(k);
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_rsp_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
            chk($sformatf("rst_rsp_err%0d", k), 32'(rsp_err[k]), 32'd0);
            chk($sformatf("rst_rsp_rdata%0d", k), rsp_rdata[k], 32'd0);
            rst_n[k] = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("rst_req_ready%0d", k), 32'(req_ready[k]), 32'd1);

        // Directed vector table on the 1-wait-state instance
        vecs.push_back('{1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, "st_word"});
        vecs.push_back('{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, "ld_word"});
        vecs.push_back('{1'b1, 32'h10, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, "st_zero"});
        vecs.push_back('{1'b1, 32'h11, 2'd0, 1'b0, 32'hFFFFFF80, 32'h0,        1'b0, "st_byte"});
        vecs.push_back('{1'b0, 32'h11, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, "ld_byte_s"});
        vecs.push_back('{1'b0, 32'h11, 2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0, "ld_byte_u"});
        vecs.push_back('{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'h00008000, 1'b0, "ld_word_b"});
        vecs.push_back('{1'b1, 32'h12, 2'd1, 1'b0, 32'h7777A5C3, 32'h0,        1'b0, "st_half"});
        vecs.push_back('{1'b0, 32'h12, 2'd1, 1'b0, 32'h0,        32'hFFFFA5C3, 1'b0, "ld_half_s"});
        vecs.push_back('{1'b0, 32'h12, 2'd1, 1'b1, 32'h0,        32'h0000A5C3, 1'b0, "ld_half_u"});
        vecs.push_back('{1'b0, 32'h10, 2'd2, 1'b1, 32'h0,        32'hA5C38000, 1'b0, "ld_word_h"});
        vecs.push_back('{1'b1, 32'h00, 2'd2, 1'b0, 32'h11112222, 32'h0,        1'b0, "st_word0"});
        vecs.push_back('{1'b0, 32'h13, 2'd1, 1'b0, 32'h0,        32'h0,        1'b1, "err_half"});
        vecs.push_back('{1'b0, 32'h12, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1, "err_word"});
        vecs.push_back('{1'b0, 32'h10, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1, "err_size"});
        vecs.push_back('{1'b1, 32'h4000, 2'd2, 1'b0, 32'hBADBAD00, 32'h0,      1'b1, "err_range"});
        vecs.push_back('{1'b1, 32'h11, 2'd1, 1'b0, 32'hFFFF,     32'h0,        1'b1, "err_st_half"});
        vecs.push_back('{1'b0, 32'h00, 2'd2, 1'b0, 32'h0,        32'h11112222, 1'b0, "range_kept"});
        vecs.push_back('{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hA5C38000, 1'b0, "err_kept"});
        vecs.push_back('{1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        32'h000000A5, 1'b0, "ld_byte_hi"});
        foreach (vecs[i]) begin
            xact(0, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, rd, er, lat);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd2);
        end

        // Response stall: rsp_ready low for 5 cycles with a new request waiting
        drive_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        @(posedge clk);
        #1 drive_req(0, 1'b0, 32'h00, 2'd2, 1'b0, 32'h0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!rsp_valid[0] && guard < 20);
        chk("stall_first_rdata", rsp_rdata[0], 32'hA5C38000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid[0]), 32'd1);
            chk("stall_rdata", rsp_rdata[0], 32'hA5C38000);
            chk("stall_err", 32'(rsp_err[0]), 32'd0);
            chk("stall_req_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        @(negedge clk);
        chk("release_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("release_no_accept", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1 scramble_req(0);
        wait_rsp(0, rd, er, lat);
        chk("after_stall_rdata", rd, 32'h11112222);
        chk("after_stall_lat", 32'(lat), 32'd2);

        // Reset during WAIT of a store on the 3-wait-state instance
        xact(1, 1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D, rd, er, lat);
        chk("ws3_st_lat", 32'(lat), 32'd4);
        drive_req(1, 1'b1, 32'h20, 2'd2, 1'b0, 32'h12345678);
        @(posedge clk);
        #1 scramble_req(1);
        @(negedge clk);
        @(negedge clk);
        rst_n[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
            chk("abort_req_ready", 32'(req_ready[1]), 32'd1);
        end
        rst_n[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid[1]), 32'd0);
        end
        xact(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, rd, er, lat);
        chk("abort_old_value", rd, 32'hCAFEF00D);
        chk("abort_ld_lat", 32'(lat), 32'd4);

        // Back-to-back on the 0-wait-state instance with rsp_ready tied high
        b2b.push_back('{1'b1, 32'h40, 2'd2, 1'b0, 32'h01234567, 32'h0,        1'b0, "b2b_st0"});
        b2b.push_back('{1'b1, 32'h44, 2'd2, 1'b0, 32'h89ABCDEF, 32'h0,        1'b0, "b2b_st1"});
        b2b.push_back('{1'b0, 32'h40, 2'd2, 1'b0, 32'h0,        32'h01234567, 1'b0, "b2b_ld0"});
        b2b.push_back('{1'b0, 32'h44, 2'd2, 1'b0, 32'h0,        32'h89ABCDEF, 1'b0, "b2b_ld1"});
        b2b.push_back('{1'b0, 32'h41, 2'd0, 1'b1, 32'h0,        32'h00000045, 1'b0, "b2b_ldb"});
        b2b.push_back('{1'b0, 32'h46, 2'd1, 1'b0, 32'h0,        32'hFFFF89AB, 1'b0, "b2b_ldh"});
        item = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (pend) begin
                chk({pv.name, "_valid"}, 32'(rsp_valid[2]), 32'd1);
                chk({pv.name, "_rdata"}, rsp_rdata[2], pv.exp_rdata);
                chk({pv.name, "_err"}, 32'(rsp_err[2]), 32'(pv.exp_err));
                pend = 1'b0;
            end else begin
                chk("b2b_idle_valid", 32'(rsp_valid[2]), 32'd0);
            end
            if (item < b2b.size()) begin
                drive_req(2, b2b[item].we, b2b[item].addr, b2b[item].size, b2b[item].uns,
                          b2b[item].wdata);
                chk("b2b_ready", 32'(req_ready[2]), 32'(cyc % 2 == 0));
                if (req_ready[2]) begin
                    pv   = b2b[item];
                    pend = 1'b1;
                    item++;
                end
            end else begin
                scramble_req(2);
            end
        end
        chk("b2b_accepts", 32'(item), 32'(b2b.size()));

        // Randomized run on the 1-wait-state instance against the reference model
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            d = $urandom;
            xact(0, 1'b1, 32'(w * 4), 2'd2, 1'b0, d, rd, er, lat);
            ref_mem[w] = d;
        end
        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [31:0] addr;
            logic [1:0]  size;
            logic        uns;
            logic [31:0] wdata;
            logic        exp_err;
            logic [31:0] exp_rd;
            int          r;
            int          s;
            r = $urandom_range(0, 9);
            if (r == 0)      addr = 32'h4000 + 32'($urandom_range(0, 63));
            else if (r == 1) addr = $urandom | 32'h0001_0000;
            else             addr = 32'($urandom_range(0, 63));
            s     = $urandom_range(0, 6);
            size  = (s < 2) ? 2'd0 : (s < 4) ? 2'd1 : (s < 6) ? 2'd2 : 2'd3;
            we    = 1'($urandom);
            uns   = 1'($urandom);
            wdata = $urandom;
            exp_err = ref_err(addr, size);
            exp_rd  = 32'd0;
            if (!exp_err) begin
                if (we) ref_mem[int'(addr >> 2)] = ref_store(ref_mem[int'(addr >> 2)], addr, size, wdata);
                else    exp_rd = ref_load(ref_mem[int'(addr >> 2)], addr, size, uns);
            end
            exp_q.push_back(exp_rd);
            xact(0, we, addr, size, uns, wdata, rd, er, lat);
            chk("rnd_rdata", rd, exp_q.pop_front());
            chk("rnd_err", 32'(er), 32'(exp_err));
            chk("rnd_lat", 32'(lat), 32'd2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
